// File: rtl/pu_ctrl_pkg.sv
// pu_ctrl_pkg: shared state encoding and default sizing for the PU iteration controller.
// Ports: none (package).
package pu_ctrl_pkg;
    localparam int NUM_PU_D   = 4;
    localparam int MAX_ITER_D = 15;
    localparam int ITER_W_D   = 4;
    localparam int IDX_W_D    = 2;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        SUM   = 3'd3,
        CHECK = 3'd4,
        FEED  = 3'd5,
        DONE  = 3'd6
    } state_t;
endpackage

// File: rtl/pu_flag_eval.sv
// pu_flag_eval: classifies the PU nonzero flags (at most one set, exactly one set, lowest set index).
// Ports: s_vec in (PU flags); le_one, one_hot, low_idx out.
module pu_flag_eval
    import pu_ctrl_pkg::*;
#(
    parameter int NUM_PU = NUM_PU_D,
    parameter int IDX_W  = IDX_W_D
) (
    input  logic [NUM_PU-1:0] s_vec,
    output logic              le_one,
    output logic              one_hot,
    output logic [IDX_W-1:0]  low_idx
);
    // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
    assign le_one  = (s_vec & (s_vec - NUM_PU'(1))) == '0;
    assign one_hot = le_one & (|s_vec);
    // Scan high to low so the last hit is the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_PU - 1; i >= 0; i--)
            if (s_vec[i]) low_idx = IDX_W'(i);
    end
endmodule

// File: rtl/pu_iter_ctrl.sv
// pu_iter_ctrl: Maxnet sequencer driving PU load/multiply/sum strobes until one PU remains or MAX_ITER passes.
// Ports: clk, rst (async high), start, s_vec in; ld_x, sel_init, mul_en, sum_en, busy, done strobes out;
//        timeout, winner_valid, winner_idx, iter_cnt held results out.
module pu_iter_ctrl
    import pu_ctrl_pkg::*;
#(
    parameter int NUM_PU   = NUM_PU_D,
    parameter int MAX_ITER = MAX_ITER_D,
    parameter int ITER_W   = ITER_W_D,
    parameter int IDX_W    = IDX_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_PU-1:0] s_vec,
    output logic              ld_x,
    output logic              sel_init,
    output logic              mul_en,
    output logic              sum_en,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              winner_valid,
    output logic [IDX_W-1:0]  winner_idx,
    output logic [ITER_W-1:0] iter_cnt
);
    state_t            r_state, w_next;
    logic [ITER_W-1:0] r_iter;
    logic              r_timeout, r_wv;
    logic [IDX_W-1:0]  r_idx;
    logic              w_le_one, w_one_hot, w_last, w_finish;
    logic [IDX_W-1:0]  w_low_idx;

    pu_flag_eval #(.NUM_PU(NUM_PU), .IDX_W(IDX_W)) u_eval (
        .s_vec   (s_vec),
        .le_one  (w_le_one),
        .one_hot (w_one_hot),
        .low_idx (w_low_idx)
    );

    // r_iter still holds the count before this CHECK, so equality with MAX_ITER-1 marks the final pass.
    assign w_last   = r_iter == ITER_W'(MAX_ITER - 1);
    assign w_finish = w_le_one | w_last;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;

    always_comb begin
        w_next   = r_state;
        ld_x     = 1'b0;
        sel_init = 1'b0;
        mul_en   = 1'b0;
        sum_en   = 1'b0;
        busy     = r_state != IDLE;
        done     = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD: begin
                ld_x     = 1'b1;
                sel_init = 1'b1;
                w_next   = MUL;
            end
            MUL: begin
                mul_en = 1'b1;
                w_next = SUM;
            end
            SUM: begin
                sum_en = 1'b1;
                w_next = CHECK;
            end
            CHECK:   w_next = w_finish ? DONE : FEED;
            FEED: begin
                ld_x   = 1'b1;
                w_next = MUL;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Results are cleared at LOAD and written only at the finishing CHECK; a single-PU finish
    // takes precedence over the iteration cap so timeout only reports an unresolved run.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_iter    <= '0;
            r_timeout <= 1'b0;
            r_wv      <= 1'b0;
            r_idx     <= '0;
        end else if (r_state == LOAD) begin
            r_iter    <= '0;
            r_timeout <= 1'b0;
            r_wv      <= 1'b0;
            r_idx     <= '0;
        end else if (r_state == CHECK) begin
            r_iter <= r_iter + ITER_W'(1);
            if (w_finish) begin
                r_timeout <= ~w_le_one;
                r_wv      <= w_one_hot;
                r_idx     <= w_low_idx;
            end
        end

    assign timeout      = r_timeout;
    assign winner_valid = r_wv;
    assign winner_idx   = r_idx;
    assign iter_cnt     = r_iter;
endmodule

// File: tb/tb_pu_iter_ctrl.sv
// tb_pu_iter_ctrl: run-level model of the Maxnet sequencer checked against the DUT every cycle.
// Ports: none (testbench).
module tb_pu_iter_ctrl;
    localparam int MI = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] s_vec = 4'b0;
    logic       ld_x, sel_init, mul_en, sum_en, busy, done, timeout, winner_valid;
    logic [1:0] winner_idx;
    logic [3:0] iter_cnt;

    pu_iter_ctrl #(.NUM_PU(4), .MAX_ITER(MI), .ITER_W(4), .IDX_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .s_vec        (s_vec),
        .ld_x         (ld_x),
        .sel_init     (sel_init),
        .mul_en       (mul_en),
        .sum_en       (sum_en),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .winner_valid (winner_valid),
        .winner_idx   (winner_idx),
        .iter_cnt     (iter_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0, m_k = 0, m_n = 1, n_chk = 0, n_fail = 0;
    bit   m_active = 1'b0;
    int   h_iter = 0, h_to = 0, h_wv = 0, h_idx = 0;
    int   f_iter = 0, f_to = 0, f_wv = 0, f_idx = 0;
    logic [3:0] pat [16];
    logic [3:0] m_pat [16];
    bit   lit_en = 1'b0;
    int   lit_t = 0, lit_idx = 0, lit_wv = 0, lit_to = 0, lit_iter = 0;

    function automatic int popc(logic [3:0] v);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int lowi(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(string name, int t, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d t=%0d actual=%0d required=%0d", name, cyc, t, act, exp);
        end
    endtask

    // Run model: on an accepted start, work out the whole run from the per-pass flag pattern.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            h_iter = 0; h_to = 0; h_wv = 0; h_idx = 0;
        end else begin
            cyc++;
            if (m_active && cyc - m_k == 4 * m_n + 2) begin
                m_active = 1'b0;
                h_iter = f_iter; h_to = f_to; h_wv = f_wv; h_idx = f_idx;
            end else if (!m_active && start) begin
                m_active = 1'b1;
                m_k = cyc - 1;
                m_pat = pat;
                m_n = 0;
                for (int p = 0; p < MI && m_n == 0; p++) begin
                    if (popc(pat[p]) <= 1) begin
                        m_n = p + 1; f_to = 0; f_wv = int'(popc(pat[p]) == 1); f_idx = lowi(pat[p]);
                    end else if (p == MI - 1) begin
                        m_n = MI; f_to = 1; f_wv = 0; f_idx = lowi(pat[p]);
                    end
                end
                f_iter = m_n;
            end
        end
    end

    // Compare process: t=1 is LOAD, passes occupy t=2..4n in groups of MUL,SUM,CHECK,FEED, done at 4n+1.
    always @(negedge clk) begin
        int t, r, e_iter, e_to, e_wv, e_idx;
        bit mid;
        t   = cyc - m_k;
        mid = m_active && t >= 2 && t <= 4 * m_n;
        r   = mid ? (t - 2) % 4 : 0;
        if (!m_active || t == 1) begin
            e_iter = h_iter; e_to = h_to; e_wv = h_wv; e_idx = h_idx;
        end else if (t == 4 * m_n + 1) begin
            e_iter = f_iter; e_to = f_to; e_wv = f_wv; e_idx = f_idx;
        end else begin
            e_iter = (t - 1) / 4; e_to = 0; e_wv = 0; e_idx = 0;
        end
        chk("ld_x", t, int'(ld_x), int'(m_active && (t == 1 || (mid && r == 3))));
        chk("sel_init", t, int'(sel_init), int'(m_active && t == 1));
        chk("mul_en", t, int'(mul_en), int'(mid && r == 0));
        chk("sum_en", t, int'(sum_en), int'(mid && r == 1));
        chk("busy", t, int'(busy), int'(m_active));
        chk("done", t, int'(done), int'(m_active && t == 4 * m_n + 1));
        chk("iter_cnt", t, int'(iter_cnt), e_iter);
        chk("timeout", t, int'(timeout), e_to);
        chk("winner_valid", t, int'(winner_valid), e_wv);
        chk("winner_idx", t, int'(winner_idx), e_idx);
        if (lit_en && done === 1'b1) begin
            chk("lit_done_time", t, t, lit_t);
            chk("lit_winner_idx", t, int'(winner_idx), lit_idx);
            chk("lit_winner_valid", t, int'(winner_valid), lit_wv);
            chk("lit_timeout", t, int'(timeout), lit_to);
            chk("lit_iter_cnt", t, int'(iter_cnt), lit_iter);
        end
        s_vec = (mid && r == 2) ? m_pat[(t - 2) / 4] : 4'($urandom);
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!m_active) return;
        end
        $display("FAIL watchdog run never finished cyc=%0d", cyc);
        $fatal(1, "watchdog");
    endtask

    task automatic set_lit(int t, int idx, int wv, int to, int it);
        lit_t = t; lit_idx = idx; lit_wv = wv; lit_to = to; lit_iter = it;
        lit_en = 1'b1;
    endtask

    task automatic fill(logic [3:0] v);
        for (int i = 0; i < 16; i++) pat[i] = v;
    endtask

    initial begin
        fill(4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // single winner on the first pass
        fill(4'b1111); pat[0] = 4'b0100;
        set_lit(5, 2, 1, 0, 1);
        do_start(); wait_idle(); lit_en = 1'b0;
        // convergence over three passes
        fill(4'b1111); pat[0] = 4'b1011; pat[1] = 4'b0011; pat[2] = 4'b0010;
        set_lit(13, 1, 1, 0, 3);
        do_start(); wait_idle(); lit_en = 1'b0;
        // iteration cap reached with every PU still active
        fill(4'b1111);
        set_lit(61, 0, 0, 1, 15);
        do_start(); wait_idle(); lit_en = 1'b0;
        // all-zero finish
        fill(4'b1111); pat[0] = 4'b0000;
        set_lit(5, 0, 0, 0, 1);
        do_start(); wait_idle(); lit_en = 1'b0;
        // asynchronous reset during SUM
        fill(4'b1111);
        do_start();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        // start pulses in MUL and FEED are ignored
        fill(4'b1111); pat[0] = 4'b1011; pat[1] = 4'b0010;
        set_lit(9, 1, 1, 0, 2);
        do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle(); lit_en = 1'b0;
        repeat (3) @(negedge clk);
        // start held high: back-to-back runs with the second LOAD clearing results
        fill(4'b1111); pat[0] = 4'b1000;
        @(negedge clk); start = 1'b1;
        repeat (9) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
